multdiv_unit: RTL and testbench

- Multi-cycle signed multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Takes the same two 32-bit register operands the ALU sees.
- Its result is selected ahead of the execute/memory latch in place of the ALU result for mul/div instructions.
- Asserts busy so the pipeline control stalls fetch/decode while an operation is in flight.

---
 rtl/multdiv_unit.sv | 179 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply / divide beside the ALU.
// Multiply: radix-2 shift-add on magnitudes, 32 iterations, sign applied at
// the end. Divide: restoring division on magnitudes, 32 iterations.
// Optional build macro MULTDIV_BOOTH4_EN switches multiply to radix-4 Booth
// recoding on the signed operands (16 iterations); results are identical.
//
// Handshake: a start is the rising cycle of ctrl_MULT or ctrl_DIV (multiply
// wins if both rise together). Operands are sampled on that edge only. busy is
// high from the start edge until the completion edge; data_resultRDY is a
// one-cycle pulse in the DONE cycle, and data_result/data_exception hold until
// the next completion. A new start at any time abandons the current op with
// no completion pulse for it.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
`ifdef MULTDIV_BOOTH4_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2 - 1);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
`endif
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mult_prev_q, div_prev_q;
  logic               neg_q, bzero_q, dovf_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH:0]     mplier_q;
  logic [WIDTH-1:0]   rem_q, dvd_q, dvs_q;

  logic               start_mul, start_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_add, mul_acc_nxt, mul_prod;
  logic               mul_ovf;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, div_quo;

  // Only the rising cycle of a control line starts an op.
  assign start_mul = ctrl_MULT & ~mult_prev_q;
  assign start_div = ctrl_DIV & ~div_prev_q & ~start_mul;

  // Unsigned magnitudes: 0x80000000 maps to 2^31 without wrapping.
  assign a_mag = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  assign dbg_state = state_q;

  // One multiply step and the final signed product built from it.
  always_comb begin
    mul_add = '0;
`ifdef MULTDIV_BOOTH4_EN
    case (mplier_q[2:0])
      3'b001, 3'b010: mul_add = mcand_q;
      3'b011:         mul_add = mcand_q << 1;
      3'b100:         mul_add = -(mcand_q << 1);
      3'b101, 3'b110: mul_add = -mcand_q;
      default:        mul_add = '0;
    endcase
    mul_acc_nxt = acc_q + mul_add;
    mul_prod    = mul_acc_nxt;
`else
    if (mplier_q[0]) mul_add = mcand_q;
    mul_acc_nxt = acc_q + mul_add;
    mul_prod    = neg_q ? -mul_acc_nxt : mul_acc_nxt;
`endif
  end

  // Overflow when the upper half is not the sign extension of the lower half.
  assign mul_ovf = (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    trial   = {rem_q, dvd_q[WIDTH-1]};
    ge      = (trial >= {1'b0, dvs_q});
    rem_nxt = ge ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
    quo_nxt = {dvd_q[WIDTH-2:0], ge};
    div_quo = neg_q ? -quo_nxt : quo_nxt;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mult_prev_q    <= 1'b0;
      div_prev_q     <= 1'b0;
      neg_q          <= 1'b0;
      bzero_q        <= 1'b0;
      dovf_q         <= 1'b0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      rem_q          <= '0;
      dvd_q          <= '0;
      dvs_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mult_prev_q    <= ctrl_MULT;
      div_prev_q     <= ctrl_DIV;
      data_resultRDY <= 1'b0;
      if (start_mul || start_div) begin
        state_q  <= start_mul ? S_MUL : S_DIV;
        cnt_q    <= '0;
        busy     <= 1'b1;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        bzero_q  <= (data_operandB == '0);
        dovf_q   <= (data_operandA == INT_MIN) && (data_operandB == '1);
        acc_q    <= '0;
`ifdef MULTDIV_BOOTH4_EN
        mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        mplier_q <= {data_operandB, 1'b0};
`else
        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
        mplier_q <= {1'b0, b_mag};
`endif
        rem_q    <= '0;
        dvd_q    <= a_mag;
        dvs_q    <= b_mag;
      end else begin
        case (state_q)
          S_MUL: begin
            acc_q <= mul_acc_nxt;
`ifdef MULTDIV_BOOTH4_EN
            mcand_q  <= mcand_q << 2;
            mplier_q <= {{2{mplier_q[WIDTH]}}, mplier_q[WIDTH:2]};
`else
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
`endif
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == MUL_LAST) begin
              data_result    <= mul_prod[WIDTH-1:0];
              data_exception <= mul_ovf;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state_q        <= S_DONE;
            end
          end
          S_DIV: begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == DIV_LAST) begin
              data_result    <= bzero_q ? '0 : (dovf_q ? INT_MIN : div_quo);
              data_exception <= bzero_q | dovf_q;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state_q        <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed + random bench for multdiv_unit with a result scoreboard.
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        clock, reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rdy_cyc = 0;
  int rdy_count = 0;
  logic [32:0] exp_q[$];

  multdiv_unit dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: {exception, result}
  function automatic logic [32:0] model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p[63:32] != {32{p[31]}}), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  // Scoreboard: compare every completion against the oldest expectation
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      logic [32:0] e;
      rdy_count++;
      rdy_cyc = cyc;
      check("rdy_busy_low", busy, 0);
      check("sb_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", data_result, e[31:0]);
        check("sb_exception", data_exception, e[32]);
      end
    end
  end

  // Driver: one-cycle start pulse; start edge recorded in start_cyc
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_rdy(input int n0, input int exp_lat, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (rdy_count > n0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_rdy_seen"}, seen, 1);
    if (seen) check({tag, "_latency"}, rdy_cyc - start_cyc, exp_lat);
  endtask

  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n0 = rdy_count;
    exp_q.push_back(model(m, a, b));
    start_op(m, d, a, b);
    wait_rdy(n0, m ? MUL_LAT : DIV_LAT, tag);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_result", data_result, 0);
    check("rst_exception", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);

    // Basic multiply
    do_op(1, 0, 32'd7, -32'sd3, "mul_7x-3");
    check("mul_7x-3_val", data_result, 32'hFFFF_FFEB);
    check("mul_7x-3_exc", data_exception, 0);

    // Multiply overflow, then most-negative operand without overflow
    do_op(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    check("mul_ovf_val", data_result, 32'h0);
    check("mul_ovf_exc", data_exception, 1);
    do_op(1, 0, 32'h8000_0000, 32'd1, "mul_min");
    check("mul_min_val", data_result, 32'h8000_0000);
    check("mul_min_exc", data_exception, 0);

    // Divide, divide by zero, divide overflow
    do_op(0, 1, -32'sd17, 32'd5, "div_-17/5");
    check("div_-17/5_val", data_result, 32'hFFFF_FFFD);
    check("div_-17/5_exc", data_exception, 0);
    do_op(0, 1, 32'd100, 32'd0, "div_by0");
    check("div_by0_val", data_result, 32'h0);
    check("div_by0_exc", data_exception, 1);
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_val", data_result, 32'h8000_0000);
    check("div_ovf_exc", data_exception, 1);

    // Held start line: only the rising cycle counts
    n0 = rdy_count;
    exp_q.push_back(model(1, 32'd3, 32'd5));
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    repeat (2) @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    wait_rdy(n0, MUL_LAT, "held");
    repeat (40) @(posedge clock);
    check("held_single_rdy", rdy_count, n0 + 1);

    // Restart: divide issued ten cycles into a multiply
    n0 = rdy_count;
    exp_q.push_back(model(1, 32'd6, 32'd7));
    start_op(1, 0, 32'd6, 32'd7);
    repeat (9) @(posedge clock);
    void'(exp_q.pop_back());
    exp_q.push_back(model(0, 32'd50, 32'd7));
    start_op(0, 1, 32'd50, 32'd7);
    wait_rdy(n0, DIV_LAT, "restart");
    check("restart_single_rdy", rdy_count, n0 + 1);
    check("restart_val", data_result, 32'd7);

    // Asynchronous reset in cycle 20 of a divide
    n0 = rdy_count;
    exp_q.push_back(model(0, 32'd1000, 32'd3));
    start_op(0, 1, 32'd1000, 32'd3);
    repeat (19) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_result", data_result, 0);
    check("arst_exception", data_exception, 0);
    check("arst_rdy", data_resultRDY, 0);
    check("arst_busy", busy, 0);
    check("arst_state", dbg_state, 0);
    void'(exp_q.pop_back());
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    check("arst_no_rdy", rdy_count, n0);

    // Simultaneous starts: multiply wins
    do_op(1, 1, 32'd6, 32'd7, "both");
    check("both_val", data_result, 32'd42);

    // Random operations
    for (int k = 0; k < 8; k++) begin
      logic m;
      logic [31:0] a, b;
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 200)) - 32'd100);
      do_op(m, ~m, a, b, m ? "rnd_mul" : "rnd_div");
    end

    repeat (3) @(posedge clock);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
